fft_peak_analyzer: RTL and testbench
====================================

Name: fft_peak_analyzer

Overview:
- Consumer end of the FAS FFT output interface; sits downstream of FAS in the analysis stage.
- Each cycle fft_valid is high, it captures one 16-bin frame (fft_d0..fft_d15).
- It scans the 16 bins sequentially, one per cycle, using squared magnitude, and reports the peak bin index on freq with a one-cycle done pulse.
- A one-frame pending buffer lets back-to-back frames (one every 16 cycles) be absorbed without loss.

Parameters:
- SKIP_DC, 0, when 1 bin 0 is excluded from the peak search.
- DW, 16, width of each real/imag component (signed, 8 integer + 8 fraction).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- fft_valid  in  1  frame strobe; all 16 fft_d words are valid in this cycle.
- fft_d0..fft_d15  in  32 each  16 ports; [31:16] = signed real, [15:0] = signed imag, bin k on fft_dk.
- done  out  1  one-cycle pulse; freq and peak_mag are updated this cycle.
- freq  out  4  index of the peak bin of the last completed frame; held until the next done.
- peak_mag  out  33  re^2+im^2 of the peak bin; held until the next done.
- busy  out  1  high while a scan is in progress.
- overflow  out  1  sticky; set when a frame is dropped.

Behaviour:
- Reset (rst low, asynchronous): done=0, freq=0, peak_mag=0, busy=0, overflow=0; work and pending banks cleared; pend_full=0; FSM goes to IDLE. Reset in the middle of a scan abandons the frame and produces no done.
- States: IDLE, SCAN.
- IDLE + fft_valid: copy all 16 words into the work bank, set cnt=0, max=0, idx=0, go to SCAN.
- SCAN, each cycle, bin = work[cnt]:
  - mag = re*re + im*im. Signed 16x16 products, each non-negative 32-bit; sum zero-extended to 33 bits, no truncation.
  - Update rule: if (mag > max) or (cnt == first eligible bin), then max=mag and idx=cnt. First eligible bin is 0, or 1 when SKIP_DC=1.
  - When SKIP_DC=1, bin 0 is never selected.
  - Comparison is strictly greater-than, so ties go to the lowest index.
- cnt==15 in SCAN:
  - Register the final comparison; next cycle done=1, freq=idx, peak_mag=max.
  - If pend_full: move pending into work, cnt=0, stay in SCAN with no idle cycle; otherwise go to IDLE.
- Latency: fft_valid sampled at edge T (from IDLE) -> bin i evaluated in cycle T+1+i -> done high in cycle T+17.
- Throughput: one frame every 16 cycles sustained; busy is high from T+1 through T+16.
- fft_valid during SCAN:
  - pend_full=0: capture into pending, set pend_full.
  - pend_full=1 and cnt!=15: drop the frame, set overflow. Current and pending frames are unaffected.
  - pend_full=1 and cnt==15: pending moves to work and the new frame enters pending; no drop.
- fft_valid in the same cycle that SCAN ends with pend_full=0: the frame goes straight into work and a new scan starts next cycle.
- Outputs are registered, with no combinational path from inputs.
- fft_d values are ignored when fft_valid is low.

Test Plan:
- Single frame: bin 1 = 0x0100_0000 (re=1.0), bin 15 = 0x0100_0000, all others 0 -> done 17 cycles after fft_valid, freq=1 (tie, lowest index wins), peak_mag=0x0_0001_0000.
- Negative components: bin 7 = 0xFF00_FF00 (-1,-1), others 0x0080_0000 -> freq=7, peak_mag=0x0_0002_0000.
- SKIP_DC=1: bin 0 = 0x7FFF_7FFF, bin 3 = 0x0010_0000, others 0 -> freq=3, peak_mag=0x0_0000_0100.
- Back-to-back: fft_valid every 16 cycles for 64 frames, alternating peak bins 1 and 15 -> 64 done pulses spaced exactly 16 cycles apart, correct freq each time, overflow=0.
- Overflow: three fft_valid pulses on consecutive cycles -> frames 1 and 2 reported (done at +17 and +33), frame 3 dropped, overflow=1 until reset.
- Reset mid-scan: rst low at cnt=8 -> all outputs 0 immediately; after release, no done until a new fft_valid.

Source files
------------

// File: rtl/fft_peak_analyzer.sv
// Peak-bin finder for 16-bin FFT frames: scans one bin per cycle by squared magnitude,
// with a single pending frame buffer so frames arriving every 16 cycles are not lost.
module fft_peak_analyzer #(
  parameter bit SKIP_DC = 1'b0,
  parameter int DW      = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fft_valid,
  input  logic [2*DW-1:0] fft_d0,
  input  logic [2*DW-1:0] fft_d1,
  input  logic [2*DW-1:0] fft_d2,
  input  logic [2*DW-1:0] fft_d3,
  input  logic [2*DW-1:0] fft_d4,
  input  logic [2*DW-1:0] fft_d5,
  input  logic [2*DW-1:0] fft_d6,
  input  logic [2*DW-1:0] fft_d7,
  input  logic [2*DW-1:0] fft_d8,
  input  logic [2*DW-1:0] fft_d9,
  input  logic [2*DW-1:0] fft_d10,
  input  logic [2*DW-1:0] fft_d11,
  input  logic [2*DW-1:0] fft_d12,
  input  logic [2*DW-1:0] fft_d13,
  input  logic [2*DW-1:0] fft_d14,
  input  logic [2*DW-1:0] fft_d15,
  output logic            done,
  output logic [3:0]      freq,
  output logic [2*DW:0]   peak_mag,
  output logic            busy,
  output logic            overflow
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [3:0] FIRST_BIN = SKIP_DC ? 4'd1 : 4'd0;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [2*DW:0]     max_q, max_d;
  logic [3:0]        idx_q, idx_d;
  logic [2*DW-1:0]   work_q [16];
  logic [2*DW-1:0]   work_d [16];
  logic [2*DW-1:0]   pend_q [16];
  logic [2*DW-1:0]   pend_d [16];
  logic              pend_full_q, pend_full_d;
  logic              done_q, done_d;
  logic [3:0]        freq_q, freq_d;
  logic [2*DW:0]     peak_q, peak_d;
  logic              busy_q, busy_d;
  logic              ovf_q, ovf_d;

  logic [2*DW-1:0]   fft_in [16];
  logic [2*DW-1:0]   cur_bin;
  logic signed [DW-1:0]   re, im;
  logic signed [2*DW-1:0] re_sq, im_sq;
  logic [2*DW:0]     mag;
  logic              last_bin;
  logic              take;
  logic [2*DW:0]     max_upd;
  logic [3:0]        idx_upd;

  always_comb begin
    fft_in[0]  = fft_d0;
    fft_in[1]  = fft_d1;
    fft_in[2]  = fft_d2;
    fft_in[3]  = fft_d3;
    fft_in[4]  = fft_d4;
    fft_in[5]  = fft_d5;
    fft_in[6]  = fft_d6;
    fft_in[7]  = fft_d7;
    fft_in[8]  = fft_d8;
    fft_in[9]  = fft_d9;
    fft_in[10] = fft_d10;
    fft_in[11] = fft_d11;
    fft_in[12] = fft_d12;
    fft_in[13] = fft_d13;
    fft_in[14] = fft_d14;
    fft_in[15] = fft_d15;
  end

  // Squares are non-negative and fit in 2*DW bits; the sum needs one extra bit.
  always_comb begin
    cur_bin  = work_q[cnt_q];
    re       = cur_bin[2*DW-1:DW];
    im       = cur_bin[DW-1:0];
    re_sq    = re * re;
    im_sq    = im * im;
    mag      = {1'b0, re_sq} + {1'b0, im_sq};
    last_bin = (state_q == SCAN) && (cnt_q == 4'd15);
    take     = (state_q == SCAN) && (cnt_q >= FIRST_BIN) &&
               ((mag > max_q) || (cnt_q == FIRST_BIN));
    max_upd  = take ? mag : max_q;
    idx_upd  = take ? cnt_q : idx_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (fft_valid) state_d = SCAN;
      SCAN: if (last_bin && !pend_full_q && !fft_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    max_d       = max_q;
    idx_d       = idx_q;
    work_d      = work_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    done_d      = 1'b0;
    freq_d      = freq_q;
    peak_d      = peak_q;
    ovf_d       = ovf_q;
    busy_d      = (state_d == SCAN);
    case (state_q)
      IDLE: begin
        if (fft_valid) begin
          work_d = fft_in;
          cnt_d  = 4'd0;
          max_d  = '0;
          idx_d  = 4'd0;
        end
      end
      SCAN: begin
        cnt_d = cnt_q + 4'd1;
        max_d = max_upd;
        idx_d = idx_upd;
        if (last_bin) begin
          done_d = 1'b1;
          freq_d = idx_upd;
          peak_d = max_upd;
          cnt_d  = 4'd0;
          max_d  = '0;
          idx_d  = 4'd0;
          // Pending frame goes first; a simultaneous arrival refills pending.
          if (pend_full_q) begin
            work_d = pend_q;
            if (fft_valid) pend_d = fft_in;
            else           pend_full_d = 1'b0;
          end else if (fft_valid) begin
            work_d = fft_in;
          end
        end else if (fft_valid) begin
          if (!pend_full_q) begin
            pend_d      = fft_in;
            pend_full_d = 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      max_q       <= '0;
      idx_q       <= '0;
      work_q      <= '{default: '0};
      pend_q      <= '{default: '0};
      pend_full_q <= 1'b0;
      done_q      <= 1'b0;
      freq_q      <= '0;
      peak_q      <= '0;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      max_q       <= max_d;
      idx_q       <= idx_d;
      work_q      <= work_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      done_q      <= done_d;
      freq_q      <= freq_d;
      peak_q      <= peak_d;
      busy_q      <= busy_d;
      ovf_q       <= ovf_d;
    end
  end

  assign done     = done_q;
  assign freq     = freq_q;
  assign peak_mag = peak_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_fft_peak_analyzer.sv
// Directed bench for fft_peak_analyzer: one instance with SKIP_DC=0 and one with SKIP_DC=1
// share the same stimulus; expected values are hand-computed per test.
module tb_fft_peak_analyzer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fft_valid = 1'b0;
  logic [31:0] fd [16];

  logic        done0, busy0, ovf0;
  logic [3:0]  freq0;
  logic [32:0] peak0;
  logic        done1, busy1, ovf1;
  logic [3:0]  freq1;
  logic [32:0] peak1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fft_peak_analyzer #(.SKIP_DC(1'b0), .DW(16)) dut0 (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(fd[0]), .fft_d1(fd[1]), .fft_d2(fd[2]), .fft_d3(fd[3]),
    .fft_d4(fd[4]), .fft_d5(fd[5]), .fft_d6(fd[6]), .fft_d7(fd[7]),
    .fft_d8(fd[8]), .fft_d9(fd[9]), .fft_d10(fd[10]), .fft_d11(fd[11]),
    .fft_d12(fd[12]), .fft_d13(fd[13]), .fft_d14(fd[14]), .fft_d15(fd[15]),
    .done(done0), .freq(freq0), .peak_mag(peak0), .busy(busy0), .overflow(ovf0)
  );

  fft_peak_analyzer #(.SKIP_DC(1'b1), .DW(16)) dut1 (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(fd[0]), .fft_d1(fd[1]), .fft_d2(fd[2]), .fft_d3(fd[3]),
    .fft_d4(fd[4]), .fft_d5(fd[5]), .fft_d6(fd[6]), .fft_d7(fd[7]),
    .fft_d8(fd[8]), .fft_d9(fd[9]), .fft_d10(fd[10]), .fft_d11(fd[11]),
    .fft_d12(fd[12]), .fft_d13(fd[13]), .fft_d14(fd[14]), .fft_d15(fd[15]),
    .done(done1), .freq(freq1), .peak_mag(peak1), .busy(busy1), .overflow(ovf1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [31:0] base);
    for (int i = 0; i < 16; i++) fd[i] = base;
  endtask

  // Called at a negedge: strobe the frame for one cycle.
  task automatic send();
    fft_valid = 1'b1;
    @(negedge clk);
    fft_valid = 1'b0;
  endtask

  task automatic run_frame(input string tag, input logic [3:0] ef0, input logic [32:0] ep0,
                           input logic [3:0] ef1, input logic [32:0] ep1);
    int lat;
    send();
    lat = 1;
    chk({tag, "_busy_start"}, busy0, 1);
    while (!done0 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, 17);
    chk({tag, "_freq0"}, freq0, ef0);
    chk({tag, "_peak0"}, peak0, ep0);
    chk({tag, "_done1"}, done1, 1);
    chk({tag, "_freq1"}, freq1, ef1);
    chk({tag, "_peak1"}, peak1, ep1);
    chk({tag, "_busy_end"}, busy0, 0);
    $display("frame %s: freq=%0d peak_mag=0x%0h latency=%0d", tag, freq0, peak0, lat);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done0, 0);
  endtask

  initial begin
    int pulses;
    bit exp_done;
    fill(32'h0);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_done", done0, 0);
    chk("rst_freq", freq0, 0);
    chk("rst_peak", peak0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_ovf", ovf0, 0);
    rst = 1'b1;
    @(negedge clk);

    // Single frame, tie between bins 1 and 15
    fill(32'h0);
    fd[1]  = 32'h0100_0000;
    fd[15] = 32'h0100_0000;
    run_frame("single", 4'd1, 33'h0_0001_0000, 4'd1, 33'h0_0001_0000);

    // Negative components
    fill(32'h0080_0000);
    fd[7] = 32'hFF00_FF00;
    run_frame("negative", 4'd7, 33'h0_0002_0000, 4'd7, 33'h0_0002_0000);

    // DC exclusion: instance 1 skips bin 0
    fill(32'h0);
    fd[0] = 32'h7FFF_7FFF;
    fd[3] = 32'h0010_0000;
    run_frame("skip_dc", 4'd0, 33'h0_7FFE_0002, 4'd3, 33'h0_0000_0100);

    // Back-to-back: 64 frames, one every 16 cycles, junk data while fft_valid is low
    pulses = 0;
    for (int n = 0; n < 16 * 64 + 24; n++) begin
      exp_done = (n >= 17) && (((n - 17) % 16) == 0) && (((n - 17) / 16) < 64);
      chk("b2b_done", done0, exp_done);
      if (done0) pulses++;
      if (exp_done) begin
        chk("b2b_freq", freq0, (((n - 17) / 16) % 2 == 1) ? 4'd15 : 4'd1);
        $display("frame b2b%0d: freq=%0d peak_mag=0x%0h", (n - 17) / 16, freq0, peak0);
      end
      if ((n % 16) == 0 && (n / 16) < 64) begin
        fill(32'h0);
        if (((n / 16) % 2) == 1) fd[15] = 32'h0100_0000;
        else                     fd[1]  = 32'h0100_0000;
        fft_valid = 1'b1;
      end else begin
        for (int i = 0; i < 16; i++) fd[i] = $urandom;
        fft_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("b2b_pulses", pulses, 64);
    chk("b2b_ovf", ovf0, 0);

    // Overflow: three consecutive frames, the third is dropped
    for (int n = 0; n < 60; n++) begin
      exp_done = (n == 17) || (n == 33);
      chk("ovf_done", done0, exp_done);
      if (n == 17) chk("ovf_freq_f1", freq0, 4'd2);
      if (n == 33) chk("ovf_freq_f2", freq0, 4'd9);
      if (exp_done) $display("frame ovf_n%0d: freq=%0d peak_mag=0x%0h", n, freq0, peak0);
      if (n == 2) chk("ovf_before", ovf0, 0);
      if (n == 3) chk("ovf_set", ovf0, 1);
      fill(32'h0);
      fft_valid = (n < 3);
      if (n == 0) fd[2] = 32'h0100_0000;
      if (n == 1) fd[9] = 32'h0100_0000;
      if (n == 2) fd[5] = 32'h0200_0000;
      @(negedge clk);
    end
    chk("ovf_sticky", ovf0, 1);

    // Reset in the middle of a scan (cnt == 8)
    fill(32'h0);
    fd[4] = 32'h0100_0000;
    send();
    repeat (8) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_done", done0, 0);
    chk("midrst_freq", freq0, 0);
    chk("midrst_peak", peak0, 0);
    chk("midrst_busy", busy0, 0);
    chk("midrst_ovf", ovf0, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < 30; n++) begin
      chk("midrst_no_done", done0, 0);
      @(negedge clk);
    end
    fill(32'h0);
    fd[6] = 32'h0000_0300;
    run_frame("after_rst", 4'd6, 33'h0_0009_0000, 4'd6, 33'h0_0009_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
